// File: rtl/mem_access_seq_if.sv
// Byte-wide data memory port between the access sequencer (master) and data memory (slave).
interface mem_access_seq_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access_seq.sv
// Sequences EX/MEM load/store instructions into 1 or 4 byte transfers and stalls the pipeline meanwhile.
// Optional per-byte ack timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_seq #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                is_mem_inst,
    input  logic                is_word,
    input  logic                mem_write_en,
    input  logic [ADDR_W-1:0]   alu_result,
    input  logic [3:0][7:0]     read_data_2,
    output logic                stall,
    mem_access_seq_if.master    mem,
    output logic [3:0][7:0]     load_data,
    output logic                load_valid,
    output logic                mem_error
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_access_seq: TIMEOUT_CYCLES must be at least 1");
    end

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [3:0][7:0]   wdata_q, wdata_d;
    logic              is_word_q, is_word_d;
    logic              we_q, we_d;
    logic [3:0][7:0]   load_data_q, load_data_d;
    logic [1:0]        last_idx;
    logic              timed_out;

`ifdef MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    assign timed_out = err_q;
`else
    assign timed_out = 1'b0;
`endif

    assign last_idx = is_word_q ? 2'd3 : 2'd0;

    // NOTE: every output and next-state value gets a default before the case so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        base_d        = base_q;
        wdata_d       = wdata_q;
        is_word_d     = is_word_q;
        we_d          = we_q;
        load_data_d   = load_data_q;
`ifdef MEM_TIMEOUT_EN
        wait_d        = wait_q;
        err_d         = err_q;
`endif
        stall         = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = base_q + ADDR_W'(byte_idx_q);
        mem.mem_wdata = wdata_q[byte_idx_q];

        unique case (state_q)
            IDLE: begin
                if (is_mem_inst) begin
                    stall       = 1'b1;
                    base_d      = alu_result;
                    wdata_d     = read_data_2;
                    is_word_d   = is_word;
                    we_d        = mem_write_en;
                    byte_idx_d  = 2'd0;
                    load_data_d = '0;
`ifdef MEM_TIMEOUT_EN
                    wait_d      = '0;
                    err_d       = 1'b0;
`endif
                    state_d     = ACCESS;
                end
            end

            ACCESS: begin
                stall       = 1'b1;
                mem.mem_req = 1'b1;
                mem.mem_we  = we_q;
                if (mem.mem_ack) begin
                    if (!we_q) begin
                        load_data_d[byte_idx_q] = mem.mem_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                    wait_d = '0;
`endif
                    if (byte_idx_q == last_idx) begin
                        state_d = DONE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                // This cycle is the TIMEOUT_CYCLES-th one without an ack for the current byte.
                else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
`endif
            end

            DONE: begin
                // The finished instruction is still presented this cycle, so is_mem_inst is ignored.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: load_data is a plain register (not a memory array), so it is reset alongside the control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_idx_q  <= 2'd0;
            base_q      <= '0;
            wdata_q     <= '0;
            is_word_q   <= 1'b0;
            we_q        <= 1'b0;
            load_data_q <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            is_word_q   <= is_word_d;
            we_q        <= we_d;
            load_data_q <= load_data_d;
`ifdef MEM_TIMEOUT_EN
            wait_q      <= wait_d;
            err_q       <= err_d;
`endif
        end
    end

    assign load_data  = load_data_q;
    assign load_valid = (state_q == DONE) && !we_q && !timed_out;
    assign mem_error  = (state_q == DONE) && timed_out;

endmodule
